// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Fetch, load/store and memory-side signals of mem_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, stall
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency memory port between instruction fetch
//            and load/store; one-cycle acks plus a combinational pipeline stall.
//            Build option ARB_ROUND_ROBIN_EN selects round-robin tie-breaking,
//            otherwise data has fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int MEM_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int                 c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sel_d;
    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_if_rdata;
    logic [DW-1:0]      r_d_rdata;

    logic               w_any_req;
    logic               w_grant;
    logic               w_grant_d;
    logic               w_last_beat;
    logic               w_mem_re;
    logic               w_mem_we;
    logic               w_if_ack;
    logic               w_d_ack;

    assign w_any_req   = bus.if_req | bus.d_req;
    assign w_grant     = (r_state == ST_IDLE) & w_any_req;
    assign w_last_beat = (r_state == ST_ACCESS) & (r_cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers whether data won the previous grant; 0 (fetch) after reset.
    logic r_last_d;

    assign w_grant_d = bus.d_req & (~bus.if_req | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = bus.d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_if_ack    = 1'b0;
        w_d_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_re = ~r_we;
                w_mem_we = r_we;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_if_ack    = ~r_sel_d;
                w_d_ack     = r_sel_d;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Requester inputs are captured only at the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sel_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_cnt   <= c_CNT_LOAD;
            r_sel_d <= w_grant_d;
            r_we    <= w_grant_d & bus.d_we;
            r_addr  <= w_grant_d ? bus.d_addr : bus.if_addr;
            r_wdata <= w_grant_d ? bus.d_wdata : '0;
        end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_last_beat && !r_we) begin
            if (r_sel_d) begin
                r_d_rdata <= bus.mem_rdata;
            end else begin
                r_if_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_re    = w_mem_re;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = w_if_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.stall     = (bus.if_req & ~w_if_ack) | (bus.d_req & ~w_d_ack);

endmodule
`default_nettype wire
